// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 4-bit writer: state encoding, default
// timing constants (50 MHz clock), clear/home opcodes and small helpers.
package lcd_pkg;

  localparam int CNT_W = 32;

  localparam int DEF_T_PWR   = 750000;
  localparam int DEF_T_INIT1 = 205000;
  localparam int DEF_T_INIT2 = 5000;
  localparam int DEF_T_SU    = 2;
  localparam int DEF_T_E     = 12;
  localparam int DEF_T_GAP   = 50;
  localparam int DEF_T_CMD   = 2000;
  localparam int DEF_T_CLR   = 82000;

  localparam logic [7:0] OP_CLEAR    = 8'h01;
  localparam logic [7:0] OP_HOME     = 8'h02;
  localparam logic [7:0] OP_HOME_ALT = 8'h03;

  localparam logic [3:0] NIB_INIT = 4'h3;
  localparam logic [3:0] NIB_4BIT = 4'h2;

  typedef enum logic [2:0] {
    ST_PWR_WAIT,
    ST_IDLE,
    ST_SETUP_HI,
    ST_E_HI,
    ST_GAP,
    ST_SETUP_LO,
    ST_E_LO,
    ST_WAIT
  } state_t;

  // A state lasting n cycles loads n-1 so that n=1 means exactly one cycle.
  function automatic logic [CNT_W-1:0] ticks(input int n);
    return CNT_W'(n - 1);
  endfunction

  function automatic logic is_clr_home(input logic rs, input logic [7:0] din);
    return !rs && (din == OP_CLEAR || din == OP_HOME || din == OP_HOME_ALT);
  endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter; o_done is high while the count sits at zero.
module lcd_timer
  import lcd_pkg::*;
#(
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_done
);

  logic [CNT_W-1:0] r_cnt;

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      r_cnt <= RST_VAL;
    else if (i_load)
      r_cnt <= i_load_val;
    else if (r_cnt != '0)
      r_cnt <= r_cnt - 1'b1;
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/lcd_nibble_writer.sv
// HD44780 4-bit write-only interface: splits each byte into two E-strobed
// nibbles. Define LCD_INIT_EN to compile in the power-on init sequence.
module lcd_nibble_writer
  import lcd_pkg::*;
#(
  parameter int T_PWR   = DEF_T_PWR,
  parameter int T_INIT1 = DEF_T_INIT1,
  parameter int T_INIT2 = DEF_T_INIT2,
  parameter int T_SU    = DEF_T_SU,
  parameter int T_E     = DEF_T_E,
  parameter int T_GAP   = DEF_T_GAP,
  parameter int T_CMD   = DEF_T_CMD,
  parameter int T_CLR   = DEF_T_CLR
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_din,
  input  logic       i_rs_in,
  input  logic       i_valid,
  output logic       o_ready,
  output logic       o_init_done,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic       o_lcd_e,
  output logic [3:0] o_sf_d
);

`ifdef LCD_INIT_EN
  localparam bit     INIT_EN   = 1'b1;
  localparam state_t RST_STATE = ST_PWR_WAIT;
`else
  localparam bit     INIT_EN   = 1'b0;
  localparam state_t RST_STATE = ST_IDLE;
`endif

  state_t           r_state;
  logic             r_ready;
  logic             r_init_done;
  logic             r_lcd_rs;
  logic             r_lcd_e;
  logic [3:0]       r_sf_d;
  logic [3:0]       r_lo_nib;
  logic             r_clr;
  logic [1:0]       r_init_step;

  state_t           w_next;
  logic [CNT_W-1:0] w_load_val;
  logic [CNT_W-1:0] w_init_wait;
  logic             w_load;
  logic             w_done;
  logic             w_accept;
  logic             w_in_init;

  assign w_accept    = (r_state == ST_IDLE) && r_ready && i_valid;
  assign w_in_init   = INIT_EN && !r_init_done;
  assign w_init_wait = (r_init_step == 2'd0) ? ticks(T_INIT1) :
                       (r_init_step == 2'd1) ? ticks(T_INIT2) : ticks(T_CMD);

  // Every state lasts at least one cycle, so any state change reloads the timer.
  assign w_load = (w_next != r_state);

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    w_next     = r_state;
    w_load_val = '0;
    unique case (r_state)
      ST_PWR_WAIT: if (w_done) begin
        w_next     = ST_SETUP_HI;
        w_load_val = ticks(T_SU);
      end
      ST_IDLE: if (w_accept) begin
        w_next     = ST_SETUP_HI;
        w_load_val = ticks(T_SU);
      end
      ST_SETUP_HI: if (w_done) begin
        w_next     = ST_E_HI;
        w_load_val = ticks(T_E);
      end
      ST_E_HI: if (w_done) begin
        if (w_in_init) begin
          w_next     = ST_WAIT;
          w_load_val = w_init_wait;
        end else begin
          w_next     = ST_GAP;
          w_load_val = ticks(T_GAP);
        end
      end
      ST_GAP: if (w_done) begin
        w_next     = ST_SETUP_LO;
        w_load_val = ticks(T_SU);
      end
      ST_SETUP_LO: if (w_done) begin
        w_next     = ST_E_LO;
        w_load_val = ticks(T_E);
      end
      ST_E_LO: if (w_done) begin
        w_next     = ST_WAIT;
        w_load_val = r_clr ? ticks(T_CLR) : ticks(T_CMD);
      end
      ST_WAIT: if (w_done) begin
        if (w_in_init && r_init_step != 2'd3) begin
          w_next     = ST_SETUP_HI;
          w_load_val = ticks(T_SU);
        end else begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= RST_STATE;
      r_ready     <= 1'b0;
      r_init_done <= 1'b0;
      r_lcd_rs    <= 1'b0;
      r_lcd_e     <= 1'b0;
      r_sf_d      <= 4'h0;
      r_lo_nib    <= 4'h0;
      r_clr       <= 1'b0;
      r_init_step <= 2'd0;
    end else begin
      r_state <= w_next;
      r_lcd_e <= (w_next == ST_E_HI) || (w_next == ST_E_LO);
      r_ready <= (w_next == ST_IDLE);
      if (w_next == ST_IDLE)
        r_init_done <= 1'b1;

      // Data and RS only move on entry to a setup state, when E is already low.
      if (w_accept) begin
        r_sf_d   <= i_din[7:4];
        r_lo_nib <= i_din[3:0];
        r_lcd_rs <= i_rs_in;
        r_clr    <= is_clr_home(i_rs_in, i_din);
      end else if (r_state == ST_GAP && w_next == ST_SETUP_LO) begin
        r_sf_d <= r_lo_nib;
      end else if (r_state == ST_PWR_WAIT && w_next == ST_SETUP_HI) begin
        r_sf_d <= NIB_INIT;
      end else if (r_state == ST_WAIT && w_next == ST_SETUP_HI) begin
        r_sf_d      <= (r_init_step == 2'd2) ? NIB_4BIT : NIB_INIT;
        r_init_step <= r_init_step + 2'd1;
      end
    end
  end

  lcd_timer #(
    .RST_VAL (CNT_W'(T_PWR - 1))
  ) u_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_done     (w_done)
  );

  assign o_ready     = r_ready;
  assign o_init_done = r_init_done;
  assign o_lcd_rs    = r_lcd_rs;
  assign o_lcd_rw    = 1'b0;
  assign o_lcd_e     = r_lcd_e;
  assign o_sf_d      = r_sf_d;

endmodule

// File: tb/tb_lcd_nibble_writer.sv
// Directed bench for lcd_nibble_writer with short timing parameters; checks
// nibble order, E timing, post-byte waits, back-to-back accepts and reset.
`timescale 1ns/1ps
module tb_lcd_nibble_writer;

  localparam int P_PWR = 3, P_I1 = 3, P_I2 = 3, P_SU = 3, P_E = 4;
  localparam int P_GAP = 3, P_CMD = 3, P_CLR = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = 8'h00;
  logic       rs_in = 1'b0;
  logic       valid = 1'b0;
  logic       o_ready, o_init_done, o_lcd_rs, o_lcd_rw, o_lcd_e;
  logic [3:0] o_sf_d;

  always #5 clk = ~clk;

  lcd_nibble_writer #(
    .T_PWR(P_PWR), .T_INIT1(P_I1), .T_INIT2(P_I2), .T_SU(P_SU),
    .T_E(P_E), .T_GAP(P_GAP), .T_CMD(P_CMD), .T_CLR(P_CLR)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_din       (din),
    .i_rs_in     (rs_in),
    .i_valid     (valid),
    .o_ready     (o_ready),
    .o_init_done (o_init_done),
    .o_lcd_rs    (o_lcd_rs),
    .o_lcd_rw    (o_lcd_rw),
    .o_lcd_e     (o_lcd_e),
    .o_sf_d      (o_sf_d)
  );

  typedef struct {
    logic [7:0] din;
    logic       rs;
    logic [3:0] hi;
    logic [3:0] lo;
    int         lat;
  } vec_t;

  typedef struct {
    int         t;
    logic [3:0] d;
    logic       rs;
  } rec_t;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  rec_t e_q[$];
  logic m_prev_e = 1'b0;
  logic m_prev_rs = 1'b0;
  logic [3:0] m_prev_d = 4'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Record every E rising edge; data and RS must hold while E stays high.
  always @(negedge clk) begin
    if (o_lcd_e && !m_prev_e)
      e_q.push_back('{t: cyc, d: o_sf_d, rs: o_lcd_rs});
    if (o_lcd_e && m_prev_e)
      check("e_hold_stable", 32'({o_lcd_rs, o_sf_d}), 32'({m_prev_rs, m_prev_d}));
    m_prev_e  = o_lcd_e;
    m_prev_rs = o_lcd_rs;
    m_prev_d  = o_sf_d;
  end

  task automatic wait_ready(input string name);
    int n = 0;
    while (!o_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) check({name, "_ready_timeout"}, 32'(o_ready), 32'd1);
  endtask

  task automatic reset_outputs(input string name);
    check({name, "_rst_e"},    32'(o_lcd_e),     32'd0);
    check({name, "_rst_rs"},   32'(o_lcd_rs),    32'd0);
    check({name, "_rst_sfd"},  32'(o_sf_d),      32'd0);
    check({name, "_rst_rdy"},  32'(o_ready),     32'd0);
    check({name, "_rst_done"}, 32'(o_init_done), 32'd0);
  endtask

  task automatic release_and_check(input string name);
    int r;
    int n;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    e_q.delete();
    r = cyc;
    #1;
    check({name, "_done_before_edge"}, 32'(o_init_done), 32'd0);
`ifdef LCD_INIT_EN
    n = 0;
    while (!o_init_done && n < 500) begin
      @(negedge clk);
      n++;
    end
    check({name, "_init_latency"}, 32'(cyc - r), 32'd43);
    check({name, "_init_ready"}, 32'(o_ready), 32'd1);
    check({name, "_init_pulses"}, 32'(e_q.size()), 32'd4);
    if (e_q.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check({name, "_init_nib"}, 32'(e_q[i].d), (i == 3) ? 32'd2 : 32'd3);
        check({name, "_init_rs"}, 32'(e_q[i].rs), 32'd0);
        check({name, "_init_t"}, 32'(e_q[i].t - r), 32'(6 + 10 * i));
      end
    end
`else
    n = 0;
    @(negedge clk);
    check({name, "_done_1cyc"}, 32'(o_init_done), 32'd1);
    check({name, "_ready_1cyc"}, 32'(o_ready), 32'd1);
    repeat (10) @(negedge clk);
    check({name, "_no_e_pulse"}, 32'(e_q.size()), 32'(n));
    check({name, "_done_held"}, 32'(o_init_done), 32'd1);
`endif
  endtask

  task automatic apply_byte(input vec_t v, input string name);
    int t0;
    int n;
    wait_ready(name);
    din = v.din;
    rs_in = v.rs;
    valid = 1'b1;
    e_q.delete();
    @(negedge clk);
    t0 = cyc;
    valid = 1'b0;
    check({name, "_ready_drop"}, 32'(o_ready), 32'd0);
    n = 0;
    while (!o_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({name, "_latency"}, 32'(cyc - t0), 32'(v.lat));
    check({name, "_pulses"}, 32'(e_q.size()), 32'd2);
    check({name, "_rw"}, 32'(o_lcd_rw), 32'd0);
    if (e_q.size() == 2) begin
      check({name, "_hi"},   32'(e_q[0].d),       32'(v.hi));
      check({name, "_lo"},   32'(e_q[1].d),       32'(v.lo));
      check({name, "_rs0"},  32'(e_q[0].rs),      32'(v.rs));
      check({name, "_rs1"},  32'(e_q[1].rs),      32'(v.rs));
      check({name, "_t_hi"}, 32'(e_q[0].t - t0),  32'd3);
      check({name, "_t_lo"}, 32'(e_q[1].t - t0),  32'd13);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  vec_t vecs[7];
  vec_t bb[3];

  initial begin
    int t0;
    int n;
    int acc[3];
    logic [3:0] exp_nib[6];

    // {din, rs, hi nibble, lo nibble, accept-to-ready cycles}
    vecs[0] = '{8'h41, 1'b1, 4'h4, 4'h1, 20};
    vecs[1] = '{8'h01, 1'b0, 4'h0, 4'h1, 37};
    vecs[2] = '{8'h28, 1'b0, 4'h2, 4'h8, 20};
    vecs[3] = '{8'h02, 1'b0, 4'h0, 4'h2, 37};
    vecs[4] = '{8'h03, 1'b1, 4'h0, 4'h3, 20};
    vecs[5] = '{8'h03, 1'b0, 4'h0, 4'h3, 37};
    vecs[6] = '{8'h81, 1'b0, 4'h8, 4'h1, 20};
    bb[0]   = '{8'h4C, 1'b1, 4'h4, 4'hC, 20};
    bb[1]   = '{8'h06, 1'b0, 4'h0, 4'h6, 20};
    bb[2]   = '{8'h7E, 1'b1, 4'h7, 4'hE, 20};
    exp_nib = '{4'h4, 4'hC, 4'h0, 4'h6, 4'h7, 4'hE};

    #1;
    reset_outputs("por");
    release_and_check("por");

    for (int i = 0; i < 7; i++)
      apply_byte(vecs[i], $sformatf("vec%0d", i));

    // VALID raised while busy must be dropped, not queued.
    wait_ready("ignore");
    din = 8'h41; rs_in = 1'b1; valid = 1'b1;
    e_q.delete();
    @(negedge clk);
    valid = 1'b0;
    repeat (2) @(negedge clk);
    din = 8'h99; rs_in = 1'b0; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    wait_ready("ignore");
    repeat (30) @(negedge clk);
    check("ignore_pulses", 32'(e_q.size()), 32'd2);
    check("ignore_idle", 32'(o_ready), 32'd1);

    // Three bytes with VALID held high: each accepted once, back to back.
    wait_ready("b2b");
    e_q.delete();
    t0 = 0;
    for (int k = 0; k < 3; k++) begin
      din = bb[k].din; rs_in = bb[k].rs; valid = 1'b1;
      n = 0;
      while (!o_ready && n < 200) begin
        @(negedge clk);
        n++;
      end
      @(negedge clk);
      if (k == 0) t0 = cyc;
      acc[k] = cyc - t0;
    end
    valid = 1'b0;
    check("b2b_acc1", 32'(acc[1]), 32'd21);
    check("b2b_acc2", 32'(acc[2]), 32'd42);
    wait_ready("b2b");
    repeat (30) @(negedge clk);
    check("b2b_pulses", 32'(e_q.size()), 32'd6);
    if (e_q.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        check($sformatf("b2b_nib%0d", i), 32'(e_q[i].d), 32'(exp_nib[i]));
        check($sformatf("b2b_rs%0d", i), 32'(e_q[i].rs), 32'(bb[i / 2].rs));
        check($sformatf("b2b_t%0d", i), 32'(e_q[i].t - t0),
              32'(21 * (i / 2) + ((i % 2 == 0) ? 3 : 13)));
      end
    end

    // Reset while E is high: E must fall at once and the writer restarts.
    wait_ready("rst_mid");
    din = 8'h55; rs_in = 1'b1; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    n = 0;
    while (!o_lcd_e && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_e_before", 32'(o_lcd_e), 32'd1);
    rst = 1'b1;
    #1;
    reset_outputs("rst_mid");
    release_and_check("rst_mid");

    apply_byte(vecs[0], "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
